// File: rtl/spi_slave_frame_pkg.sv
// Shared types and constants for the SPI responder.
`timescale 1ns/1ps
package spi_slave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OOB   = 2'd1,
    FRAME = 2'd2
  } spi_state_t;

  localparam int SPI_WORD_BITS = 32;
  localparam int SPI_OOB_BITS  = 8;

  // Bit counter value that marks the final bit of the current item.
  function automatic logic [4:0] last_bit_idx(input spi_state_t s);
    if (s == OOB) begin
      return 5'(SPI_OOB_BITS - 1);
    end
    return 5'(SPI_WORD_BITS - 1);
  endfunction

endpackage

// File: rtl/spi_slave_frame_sync_edge.sv
// N-stage synchronizer with registered one-cycle rise/fall pulses.
// The level output appears STAGES cycles after the pin changes and the
// pulses one cycle later.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;

  // Shift the asynchronous pin through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  // Compare the synchronized level with its previous value to form edge pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[STAGES-1] & r_prev;
    end
  end

  assign q    = r_sync[STAGES-1];
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: rtl/spi_slave_frame.sv
// SPI responder: oversampled SPI pins, OOB byte mode (spi_frame high) and
// framed 32-bit word mode (spi_frame low), LSB first. Receive items leave
// as one-cycle pulses; transmit items come from a one-entry holding register.
//
// Transmit handshake: a word moves into the holding register on any clock
// edge where tx_valid & tx_ready are both high; tx_ready is simply "holding
// register empty", it never depends on tx_valid, and tx_data only needs to
// be stable while tx_valid is high.
`timescale 1ns/1ps
module spi_slave_frame
  import spi_slave_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] IDLE_TX     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_cs,
  input  logic        spi_frame,
  output logic        spi_miso,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        rx_oob,
  output logic        rx_first,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_underrun,
  output logic        err_abort,
  output logic [1:0]  dbg_state
);

  // Synchronized pins and edge pulses.
  logic w_sck_q_unused;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_mosi_q;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;
  logic w_cs_q_unused;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_frame_q;
  logic w_fr_rise;
  logic w_fr_fall;

  // FSM and datapath registers.
  spi_state_t  r_state;
  spi_state_t  w_state_nxt;
  logic [4:0]  r_cnt;
  logic        r_load_pend;
  logic        r_first_pend;
  logic [31:0] r_rx_sh;
  logic [31:0] r_tx_sh;
  logic        r_miso;
  logic [31:0] r_hold;
  logic        r_hold_full;
  logic [31:0] r_rx_data;
  logic        r_rx_valid;
  logic        r_rx_oob;
  logic        r_rx_first;
  logic        r_underrun;
  logic        r_abort;

  // Control strobes from the FSM.
  logic        w_enter;
  logic        w_exit;
  logic        w_active;
  logic        w_bit_rise;
  logic        w_bit_fall;
  logic        w_last;
  logic        w_item_done;
  logic        w_load;
  logic        w_abort;
  logic        w_accept;
  logic [31:0] w_rx_next;
  logic [31:0] w_load_word;

  // spi_cs resets to the asserted level so that a pin held low through reset
  // never produces a falling edge: the FSM waits for a real high-then-low.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d(spi_clk),
    .q(w_sck_q_unused), .rise(w_sck_rise), .fall(w_sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi),
    .q(w_mosi_q), .rise(w_mosi_rise_unused), .fall(w_mosi_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs),
    .q(w_cs_q_unused), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_frame (
    .clk(clk), .rst_n(rst_n), .d(spi_frame),
    .q(w_frame_q), .rise(w_fr_rise), .fall(w_fr_fall)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and per-cycle strobes; spi_cs rise outranks a frame edge.
  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = w_frame_q ? OOB : FRAME;
          w_enter     = 1'b1;
        end
      end
      OOB: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_exit      = 1'b1;
        end else if (w_fr_fall) begin
          w_state_nxt = FRAME;
          w_exit      = 1'b1;
          w_enter     = 1'b1;
        end
      end
      FRAME: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_exit      = 1'b1;
        end else if (w_fr_rise) begin
          w_state_nxt = OOB;
          w_exit      = 1'b1;
          w_enter     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Bit-level strobes: clock edges only count while staying in an active state.
  always_comb begin
    w_active    = (r_state != IDLE) && !w_exit;
    w_bit_rise  = w_active & w_sck_rise;
    w_bit_fall  = w_active & w_sck_fall;
    w_last      = (r_cnt == last_bit_idx(r_state));
    w_item_done = w_bit_rise & w_last;
    w_load      = w_enter | (w_bit_fall & r_load_pend);
    w_abort     = w_exit & (r_cnt != 5'd0);
    w_accept    = tx_valid & ~r_hold_full;
    w_rx_next   = {w_mosi_q, r_rx_sh[31:1]};
    w_load_word = r_hold_full ? r_hold : IDLE_TX;
  end

  // Bit counter plus the pending-load and first-word flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= 5'd0;
      r_load_pend  <= 1'b0;
      r_first_pend <= 1'b0;
    end else begin
      if (w_enter || w_exit || (r_state == IDLE)) begin
        r_cnt       <= 5'd0;
        r_load_pend <= 1'b0;
      end else if (w_bit_rise) begin
        r_cnt       <= w_last ? 5'd0 : r_cnt + 5'd1;
        r_load_pend <= w_last;
      end else if (w_bit_fall) begin
        r_load_pend <= 1'b0;
      end

      if (w_enter) begin
        r_first_pend <= (w_state_nxt == FRAME);
      end else if (w_exit) begin
        r_first_pend <= 1'b0;
      end else if (w_item_done && (r_state == FRAME)) begin
        r_first_pend <= 1'b0;
      end
    end
  end

  // Receive shifter (fills from the top, LSB first) and the output pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_sh    <= 32'd0;
      r_rx_data  <= 32'd0;
      r_rx_valid <= 1'b0;
      r_rx_oob   <= 1'b0;
      r_rx_first <= 1'b0;
    end else begin
      r_rx_valid <= w_item_done;
      if (w_bit_rise) begin
        r_rx_sh <= w_rx_next;
      end
      if (w_item_done) begin
        r_rx_oob   <= (r_state == OOB);
        r_rx_first <= (r_state == FRAME) & r_first_pend;
        r_rx_data  <= (r_state == OOB) ? {24'd0, w_rx_next[31:24]} : w_rx_next;
      end
    end
  end

  // Transmit shifter: a load presents bit 0, later falling edges advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_sh <= 32'd0;
      r_miso  <= 1'b0;
    end else if (w_load) begin
      r_tx_sh <= w_load_word;
      r_miso  <= w_load_word[0];
    end else if (w_bit_fall) begin
      r_tx_sh <= {1'b0, r_tx_sh[31:1]};
      r_miso  <= r_tx_sh[1];
    end
  end

  // Holding register; a load in the same cycle as an accept sees it empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold      <= 32'd0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  // Status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_underrun <= w_load & ~r_hold_full;
      r_abort    <= w_abort;
    end
  end

  assign spi_miso    = r_miso;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_oob      = r_rx_oob;
  assign rx_first    = r_rx_first;
  assign tx_ready    = ~r_hold_full;
  assign tx_underrun = r_underrun;
  assign err_abort   = r_abort;
  assign dbg_state   = r_state;

endmodule
